fsm_counter_v3: RTL and testbench
=================================

FSM_COUNTER_V3 -- requirements
Module: fsm_counter_v3

Interface
REQ-001 Parameter WIDTH, default 8: width of count_out.
REQ-002 Parameter MAX_VAL, default 255: terminal count, 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 Parameter SKIP_VAL, default 5: skip-load value, 0 <= SKIP_VAL <= MAX_VAL.
REQ-004 Parameter WRAP_MODE, default 1: 1 = wrap at MAX_VAL, 0 = stop at MAX_VAL.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level enable; counting runs while high.
REQ-008 skip  input  1  level request to load SKIP_VAL.
REQ-009 pause  input  1  level request to hold the current count.
REQ-010 count_out  output  WIDTH  registered count value.
REQ-011 skip_hit  output  1  registered; high for each cycle a skip load took effect.
REQ-012 wrap_pulse  output  1  registered; one-cycle pulse when count wraps MAX_VAL->0.
REQ-013 done  output  1  registered; high while in DONE.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 state_out  output  2  current state encoding.

Function
REQ-016 States SHALL be IDLE=0, COUNT=1, PAUSE=2, DONE=3.
REQ-017 Input priority each cycle SHALL be: start=0 > skip > pause > count/terminal handling.
REQ-018 IDLE: count_out held 0; start=1 -> COUNT next cycle, count_out stays 0 that cycle.
REQ-019 Any state with start=0 -> IDLE next cycle, count_out cleared to 0, all flags 0.
REQ-020 COUNT or PAUSE with skip=1 -> count_out=SKIP_VAL next cycle, skip_hit=1 that cycle, state COUNT.
REQ-021 skip held N cycles SHALL hold count_out at SKIP_VAL with skip_hit high for N cycles.
REQ-022 COUNT with pause=1 (no skip) -> PAUSE, count_out unchanged; PAUSE with pause=0 -> COUNT, counting resumes following cycle.
REQ-023 COUNT, count_out < MAX_VAL -> count_out+1 per cycle.
REQ-024 COUNT, count_out == MAX_VAL, WRAP_MODE=1 -> count_out=0, wrap_pulse=1 for one cycle, stay COUNT.
REQ-025 COUNT, count_out == MAX_VAL, WRAP_MODE=0 -> DONE, count_out held at MAX_VAL, done=1.
REQ-026 DONE SHALL ignore skip and pause; exits only via start=0 (REQ-019).
REQ-027 Skip landing on MAX_VAL SHALL be handled by REQ-024/025 on the next counting cycle.
REQ-028 Arithmetic SHALL be WIDTH bits unsigned; no overflow beyond MAX_VAL is ever produced.
REQ-029 Illegal parameter combinations (REQ-002, REQ-003) SHALL stop elaboration with an error.

Reset
REQ-030 rstn=0 SHALL immediately force state IDLE, count_out=0, skip_hit=0, wrap_pulse=0, done=0, busy=0.
REQ-031 Reset asserted mid-count SHALL abort counting with no pulse emitted; release returns to IDLE behaviour.
REQ-032 All registers SHALL share the one asynchronous reset; no synchronous reset path.

Structure
REQ-033 Shared package fsm_counter_pkg SHALL hold the state typedef/encoding and default parameter constants.
REQ-034 Single module; no sub-module is natural (next-state logic and datapath stay in fsm_counter_v3).

Verification (WIDTH=8, MAX_VAL=9, SKIP_VAL=5)
REQ-035 Reset 100 ns, start=1 -> count_out 0,1,...,9,0 with wrap_pulse high only on the 9->0 cycle.
REQ-036 Counting at 2, skip=1 for 1 cycle -> count_out 5 with skip_hit=1, then 6,7; skip held 3 cycles -> 5,5,5.
REQ-037 Counting at 3, pause=1 for 4 cycles -> count_out holds 3, state_out=2; pause=0 -> 4 next-but-one cycle per REQ-022.
REQ-038 WRAP_MODE=0 -> count_out stops at 9, done=1, skip/pause ignored; start=0 -> IDLE, count_out=0.
REQ-039 pause=1 and skip=1 same cycle -> skip wins (count_out=5); start=0 with skip=1 -> IDLE, count_out=0.
REQ-040 rstn pulsed low at count 7, asynchronous to clk -> outputs 0 before next edge; release with start=1 restarts from 0.

Source files
------------

// File: rtl/fsm_counter_pkg.sv
// Shared state encoding and default parameter values for the counter FSM.
package fsm_counter_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_VAL   = 255;
  localparam int unsigned DEF_SKIP_VAL  = 5;
  localparam int unsigned DEF_WRAP_MODE = 1;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fsm_counter_v3.sv
// Up-counter FSM with skip-load, pause, and wrap-or-stop terminal handling.
// Every output is a register that is loaded from the next-state logic.
module fsm_counter_v3
  import fsm_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_VAL   = DEF_MAX_VAL,
  parameter int unsigned SKIP_VAL  = DEF_SKIP_VAL,
  parameter int unsigned WRAP_MODE = DEF_WRAP_MODE
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               skip,
  input  logic               pause,
  output logic [WIDTH-1:0]   count_out,
  output logic               skip_hit,
  output logic               wrap_pulse,
  output logic               done,
  output logic               busy,
  output logic [STATE_W-1:0] state_out
);

  // Reject parameter sets that could not be represented or reached.
  if (WIDTH == 0) begin : g_bad_width
    $error("fsm_counter_v3: WIDTH must be at least 1");
  end
  if (MAX_VAL == 0) begin : g_bad_max_low
    $error("fsm_counter_v3: MAX_VAL must be at least 1");
  end
  if ((WIDTH < 32) && (MAX_VAL > ((32'd1 << WIDTH) - 32'd1))) begin : g_bad_max_high
    $error("fsm_counter_v3: MAX_VAL does not fit in WIDTH bits");
  end
  if (SKIP_VAL > MAX_VAL) begin : g_bad_skip
    $error("fsm_counter_v3: SKIP_VAL must not exceed MAX_VAL");
  end
  if (WRAP_MODE > 1) begin : g_bad_wrap
    $error("fsm_counter_v3: WRAP_MODE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] SKIP_W = WIDTH'(SKIP_VAL);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_d;
  logic             skip_hit_d;
  logic             wrap_pulse_d;
  logic             done_d;
  logic             busy_d;

  // State and output registers, all on the single asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      count_out  <= '0;
      skip_hit   <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_out  <= count_d;
      skip_hit   <= skip_hit_d;
      wrap_pulse <= wrap_pulse_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

  // Next state and next outputs; priority is start=0, then skip, then pause.
  always_comb begin
    state_d      = state_q;
    count_d      = count_out;
    skip_hit_d   = 1'b0;
    wrap_pulse_d = 1'b0;
    done_d       = 1'b0;

    if (!start) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_COUNT;
          count_d = '0;
        end
        ST_COUNT, ST_PAUSE: begin
          if (skip) begin
            state_d    = ST_COUNT;
            count_d    = SKIP_W;
            skip_hit_d = 1'b1;
          end else if (state_q == ST_PAUSE) begin
            // Leaving pause spends one cycle in COUNT before the next increment.
            if (!pause) begin
              state_d = ST_COUNT;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else if (count_out >= MAX_W) begin
            if (WRAP_MODE != 0) begin
              count_d      = '0;
              wrap_pulse_d = 1'b1;
            end else begin
              state_d = ST_DONE;
              count_d = MAX_W;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_out + ONE_W;
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_fsm_counter_v3.sv
// Directed bench for fsm_counter_v3 (WIDTH=8, MAX_VAL=9, SKIP_VAL=5).
// Instance a wraps at MAX_VAL, instance b stops there; both share stimulus.
`timescale 1ns/1ps
module tb_fsm_counter_v3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       skip;
  logic       pause;

  logic [7:0] count_a, count_b;
  logic       sh_a, sh_b, wp_a, wp_b, dn_a, dn_b, by_a, by_b;
  logic [1:0] st_a, st_b;

  // Observed tuple: {count, state, skip_hit, wrap_pulse, done, busy}
  logic [13:0] obs_a, obs_b;
  assign obs_a = {count_a, st_a, sh_a, wp_a, dn_a, by_a};
  assign obs_b = {count_b, st_b, sh_b, wp_b, dn_b, by_b};

  logic [13:0] sbq[$];
  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] I = 2'd0, C = 2'd1, P = 2'd2, D = 2'd3;

  fsm_counter_v3 #(.WIDTH(8), .MAX_VAL(9), .SKIP_VAL(5), .WRAP_MODE(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .skip(skip), .pause(pause),
    .count_out(count_a), .skip_hit(sh_a), .wrap_pulse(wp_a), .done(dn_a),
    .busy(by_a), .state_out(st_a)
  );

  fsm_counter_v3 #(.WIDTH(8), .MAX_VAL(9), .SKIP_VAL(5), .WRAP_MODE(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .skip(skip), .pause(pause),
    .count_out(count_b), .skip_hit(sh_b), .wrap_pulse(wp_b), .done(dn_b),
    .busy(by_b), .state_out(st_b)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [7:0] c, input logic [1:0] s,
                                     input logic sh, input logic wp,
                                     input logic dn, input logic by);
    return {c, s, sh, wp, dn, by};
  endfunction

  task automatic push(input logic [7:0] c, input logic [1:0] s,
                      input logic sh, input logic wp, input logic dn, input logic by);
    sbq.push_back(mk(c, s, sh, wp, dn, by));
  endtask

  task automatic check(input string tag, input logic sel_b);
    logic [13:0] e;
    logic [13:0] o;
    e = sbq.pop_front();
    o = sel_b ? obs_b : obs_a;
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed cnt=%0d st=%0d sh/wp/dn/by=%b%b%b%b, expected cnt=%0d st=%0d sh/wp/dn/by=%b%b%b%b",
             tag, o[13:6], o[5:4], o[3], o[2], o[1], o[0],
             e[13:6], e[5:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // Drive inputs at negedge, queue the expectation, compare just after posedge.
  task automatic step(input string tag, input logic sel_b,
                      input logic st, input logic sk, input logic pa,
                      input logic [7:0] c, input logic [1:0] s,
                      input logic sh, input logic wp, input logic dn, input logic by);
    @(negedge clk);
    start = st;
    skip  = sk;
    pause = pa;
    push(c, s, sh, wp, dn, by);
    @(posedge clk);
    #1;
    check(tag, sel_b);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    skip  = 1'b0;
    pause = 1'b0;

    // Reset state on both instances.
    #50;
    push(8'd0, I, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_a", 1'b0);
    push(8'd0, I, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_b", 1'b1);
    #50;
    rstn = 1'b1;

    // Count 0..9 then wrap to 0 with a single wrap pulse.
    step("start_first", 1'b0, 1, 0, 0, 8'd0, C, 0, 0, 0, 1);
    for (int k = 1; k <= 9; k++)
      step("count_up", 1'b0, 1, 0, 0, 8'(k), C, 0, 0, 0, 1);
    step("wrap", 1'b0, 1, 0, 0, 8'd0, C, 0, 1, 0, 1);
    step("after_wrap", 1'b0, 1, 0, 0, 8'd1, C, 0, 0, 0, 1);

    // Skip for one cycle at 2, then skip held three cycles.
    step("stop_idle", 1'b0, 0, 0, 0, 8'd0, I, 0, 0, 0, 0);
    step("restart", 1'b0, 1, 0, 0, 8'd0, C, 0, 0, 0, 1);
    step("cnt1", 1'b0, 1, 0, 0, 8'd1, C, 0, 0, 0, 1);
    step("cnt2", 1'b0, 1, 0, 0, 8'd2, C, 0, 0, 0, 1);
    step("skip1", 1'b0, 1, 1, 0, 8'd5, C, 1, 0, 0, 1);
    step("post_skip6", 1'b0, 1, 0, 0, 8'd6, C, 0, 0, 0, 1);
    step("post_skip7", 1'b0, 1, 0, 0, 8'd7, C, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      step("skip_held", 1'b0, 1, 1, 0, 8'd5, C, 1, 0, 0, 1);
    step("skip_release", 1'b0, 1, 0, 0, 8'd6, C, 0, 0, 0, 1);

    // Pause at 3 for four cycles, then resume one cycle later.
    step("stop_idle2", 1'b0, 0, 0, 0, 8'd0, I, 0, 0, 0, 0);
    for (int k = 0; k <= 3; k++)
      step("count_to3", 1'b0, 1, 0, 0, 8'(k), C, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      step("pause_hold", 1'b0, 1, 0, 1, 8'd3, P, 0, 0, 0, 1);
    step("unpause", 1'b0, 1, 0, 0, 8'd3, C, 0, 0, 0, 1);
    step("resume4", 1'b0, 1, 0, 0, 8'd4, C, 0, 0, 0, 1);

    // Skip beats pause; start=0 beats skip.
    step("skip_over_pause", 1'b0, 1, 1, 1, 8'd5, C, 1, 0, 0, 1);
    step("stop_over_skip", 1'b0, 0, 1, 0, 8'd0, I, 0, 0, 0, 0);

    // Stop mode: count to 9, latch DONE, ignore skip/pause, exit on start=0.
    for (int k = 0; k <= 9; k++)
      step("b_count", 1'b1, 1, 0, 0, 8'(k), C, 0, 0, 0, 1);
    step("b_done", 1'b1, 1, 0, 0, 8'd9, D, 0, 0, 1, 1);
    step("b_done_skip", 1'b1, 1, 1, 0, 8'd9, D, 0, 0, 1, 1);
    step("b_done_pause", 1'b1, 1, 0, 1, 8'd9, D, 0, 0, 1, 1);
    step("b_exit", 1'b1, 0, 0, 0, 8'd0, I, 0, 0, 0, 0);

    // Asynchronous reset at count 7, then restart from 0.
    for (int k = 0; k <= 7; k++)
      step("count_to7", 1'b0, 1, 0, 0, 8'(k), C, 0, 0, 0, 1);
    #1;
    rstn = 1'b0;
    #1;
    push(8'd0, I, 0, 0, 0, 0);
    check("async_reset", 1'b0);
    rstn = 1'b1;
    step("post_reset0", 1'b0, 1, 0, 0, 8'd0, C, 0, 0, 0, 1);
    step("post_reset1", 1'b0, 1, 0, 0, 8'd1, C, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
